// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx: producers burst at clock rate, uart_tx drains at baud.
// A one-cycle gap after each handoff keeps a byte from being taken twice.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              gap;
  logic              wr_en;
  logic              rd_en;

  assign empty    = (count == '0);
  assign full     = (count == CAP);
  assign in_ready = !full;
  assign tx_valid = !empty && !gap;
  assign tx_data  = mem[rd_ptr];
  assign wr_en    = in_valid && in_ready;
  assign rd_en    = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      gap      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= in_valid && full;
      gap      <= rd_en;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
